// File: rtl/fix_pkg.sv
// fix_pkg: shared types and byte constants for the FIX session manager.
package fix_pkg;

  // Per-host session state.
  typedef enum logic [1:0] {
    HOST_IDLE,
    HOST_CONNECTING,
    HOST_CONNECTED,
    HOST_DISCONNECTING
  } host_state_t;

  // Framer position inside the received byte stream.
  typedef enum logic [2:0] {
    P_MSG_START,  // next byte opens a new message (and a new field)
    P_FIELD,      // next byte opens a new field
    P_GOT1,       // field so far is "1"
    P_GOT10,      // field so far is "10"
    P_DIGITS,     // inside "10=" collecting checksum digits
    P_SKIP,       // inside some other field, waiting for SOH
    P_RESYNC      // message discarded, waiting for SOH
  } parse_state_t;

  localparam logic [7:0] SOH      = 8'h01;
  localparam logic [7:0] ASCII_1  = 8'h31;
  localparam logic [7:0] ASCII_EQ = 8'h3D;
  localparam logic [7:0] ASCII_0  = 8'h30;
  localparam logic [7:0] ASCII_9  = 8'h39;

  function automatic logic is_digit(input logic [7:0] b);
    return (b >= ASCII_0) && (b <= ASCII_9);
  endfunction

endpackage

// File: rtl/fix_checksum.sv
// fix_checksum: running byte sum, snapshot of the sum at each field start,
// decimal decoder for the "10=" digits and the final compare.
module fix_checksum
  import fix_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] byte_i,
  input  logic       byte_en_i,      // byte accepted by the framer
  input  logic       msg_first_i,    // byte is the first of a message
  input  logic       field_first_i,  // byte is the first of a field
  input  logic       digit_clear_i,  // "=" of the checksum field seen
  input  logic       digit_en_i,     // byte is a checksum digit
  output logic       ok_o
);

  logic [7:0] acc_q, snap_q;
  logic [9:0] val_q, val_d;
  logic [7:0] digit;

  assign digit = byte_i - ASCII_0;
  assign val_d = (val_q * 10'd10) + {2'b00, digit};

  // Sum restarts with each message; the snapshot holds the sum of every byte
  // before the current field, which is what "10=" is compared against.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q  <= '0;
      snap_q <= '0;
      val_q  <= '0;
    end else begin
      if (byte_en_i) begin
        acc_q <= (msg_first_i ? 8'h00 : acc_q) + byte_i;
        if (field_first_i) snap_q <= msg_first_i ? 8'h00 : acc_q;
      end
      if (digit_clear_i)   val_q <= '0;
      else if (digit_en_i) val_q <= val_d;
    end
  end

  assign ok_o = (val_q == {2'b00, snap_q});

endmodule

// File: rtl/fix_session_mgr.sv
// fix_session_mgr: per-host FIX session FSMs with one outstanding connect
// attempt, plus a single-stream message framer. Build option FIX_CHECKSUM_EN
// adds the checksum compare; without it checksum_ok_o is tied high.
module fix_session_mgr
  import fix_pkg::*;
#(
  parameter int NUM_HOSTS    = 4,
  parameter int HOST_W       = $clog2(NUM_HOSTS),
  parameter int CONN_TIMEOUT = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 connect_i,
  input  logic [HOST_W-1:0]    connect_to_host_i,
  input  logic                 disconnect_i,
  input  logic [HOST_W-1:0]    disconnect_host_i,
  input  logic                 connected_i,
  input  logic [HOST_W-1:0]    connected_host_addr_i,
  input  logic [7:0]           message_i,
  input  logic                 valid_i,
  input  logic [HOST_W-1:0]    msg_host_i,
  output logic                 connect_req_o,
  output logic [HOST_W-1:0]    connect_addr_o,
  output logic                 disconnect_o,
  output logic [HOST_W-1:0]    disconnect_host_num_o,
  output logic                 busy_o,
  output logic                 timeout_o,
  output logic [NUM_HOSTS-1:0] host_connected_o,
  output logic                 message_received_o,
  output logic [HOST_W-1:0]    msg_src_o,
  output logic                 checksum_ok_o
);

  localparam int               CNT_W    = $clog2(CONN_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CONN_TIMEOUT - 1);

  host_state_t        host_q [NUM_HOSTS];
  host_state_t        host_d [NUM_HOSTS];
  logic               busy_q, busy_d;
  logic [HOST_W-1:0]  pend_q, pend_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               connect_req_q, connect_req_d;
  logic [HOST_W-1:0]  connect_addr_q, connect_addr_d;
  logic               disconnect_q, disconnect_d;
  logic [HOST_W-1:0]  disc_host_q, disc_host_d;
  logic               timeout_q, timeout_d;

  parse_state_t       pst_q, pst_d, pst_eff;
  logic [1:0]         dcnt_q, dcnt_d;
  logic [HOST_W-1:0]  cur_host_q, cur_host_d;
  logic               msg_rcv_q, msg_rcv_d;
  logic [HOST_W-1:0]  msg_src_q, msg_src_d;
  logic               byte_ok, restart;

  // Session state, attempt tracking and registered request pulses.
  // NOTE: the host state array is only NUM_HOSTS entries and every entry must
  // start IDLE, so it is reset like ordinary flops rather than left unreset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_HOSTS; i++) host_q[i] <= HOST_IDLE;
      busy_q         <= 1'b0;
      pend_q         <= '0;
      cnt_q          <= '0;
      connect_req_q  <= 1'b0;
      connect_addr_q <= '0;
      disconnect_q   <= 1'b0;
      disc_host_q    <= '0;
      timeout_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      host_q         <= host_d;
      busy_q         <= busy_d;
      pend_q         <= pend_d;
      cnt_q          <= cnt_d;
      connect_req_q  <= connect_req_d;
      connect_addr_q <= connect_addr_d;
      disconnect_q   <= disconnect_d;
      disc_host_q    <= disc_host_d;
      timeout_q      <= timeout_d;
    end
  end

  // Session next state: ack beats expiry, disconnect beats both, and a
  // connect to the disconnect target in the same cycle is dropped.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    host_d         = host_q;
    busy_d         = busy_q;
    pend_d         = pend_q;
    cnt_d          = cnt_q;
    connect_req_d  = 1'b0;
    connect_addr_d = '0;
    disconnect_d   = 1'b0;
    disc_host_d    = '0;
    timeout_d      = 1'b0;

    for (int i = 0; i < NUM_HOSTS; i++)
      if (host_q[i] == HOST_DISCONNECTING) host_d[i] = HOST_IDLE;

    if (busy_q) cnt_d = cnt_q + CNT_W'(1);

    if (connected_i && host_q[connected_host_addr_i] == HOST_CONNECTING) begin
      host_d[connected_host_addr_i] = HOST_CONNECTED;
      busy_d = 1'b0;
    end else if (busy_q && cnt_q == CNT_LAST) begin
      host_d[pend_q] = HOST_IDLE;
      busy_d    = 1'b0;
      timeout_d = 1'b1;
    end

    if (disconnect_i && (host_q[disconnect_host_i] == HOST_CONNECTED ||
                         host_q[disconnect_host_i] == HOST_CONNECTING)) begin
      host_d[disconnect_host_i] = HOST_DISCONNECTING;
      disconnect_d = 1'b1;
      disc_host_d  = disconnect_host_i;
      if (host_q[disconnect_host_i] == HOST_CONNECTING) begin
        busy_d    = 1'b0;
        timeout_d = 1'b0;
      end
    end

    if (connect_i && !busy_q && host_q[connect_to_host_i] == HOST_IDLE &&
        !(disconnect_i && disconnect_host_i == connect_to_host_i)) begin
      host_d[connect_to_host_i] = HOST_CONNECTING;
      busy_d         = 1'b1;
      pend_d         = connect_to_host_i;
      cnt_d          = '0;
      connect_req_d  = 1'b1;
      connect_addr_d = connect_to_host_i;
    end
  end

  // A byte counts only if strobed from a connected host; a byte from a
  // different host than the message in progress restarts the framer.
  assign byte_ok = valid_i && (host_q[msg_host_i] == HOST_CONNECTED);
  assign restart = byte_ok && (pst_q != P_MSG_START) && (msg_host_i != cur_host_q);
  assign pst_eff = restart ? P_MSG_START : pst_q;

  // Framer state and registered end-of-message pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pst_q      <= P_MSG_START;
      dcnt_q     <= '0;
      cur_host_q <= '0;
      msg_rcv_q  <= 1'b0;
      msg_src_q  <= '0;
    end else begin
      pst_q      <= pst_d;
      dcnt_q     <= dcnt_d;
      cur_host_q <= cur_host_d;
      msg_rcv_q  <= msg_rcv_d;
      msg_src_q  <= msg_src_d;
    end
  end

  // Framer next state: find "10=", take exactly three digits, end on SOH.
  always_comb begin
    pst_d      = pst_q;
    dcnt_d     = dcnt_q;
    cur_host_d = cur_host_q;
    msg_rcv_d  = 1'b0;
    msg_src_d  = '0;
    if (byte_ok) begin
      cur_host_d = msg_host_i;
      pst_d      = pst_eff;
      case (pst_eff)
        P_MSG_START, P_FIELD: begin
          if (message_i == SOH)          pst_d = P_FIELD;
          else if (message_i == ASCII_1) pst_d = P_GOT1;
          else                           pst_d = P_SKIP;
        end
        P_GOT1: begin
          if (message_i == ASCII_0)   pst_d = P_GOT10;
          else if (message_i == SOH)  pst_d = P_FIELD;
          else                        pst_d = P_SKIP;
        end
        P_GOT10: begin
          if (message_i == ASCII_EQ) begin
            pst_d  = P_DIGITS;
            dcnt_d = '0;
          end else if (message_i == SOH) begin
            pst_d = P_FIELD;
          end else begin
            pst_d = P_SKIP;
          end
        end
        P_DIGITS: begin
          if (is_digit(message_i)) begin
            if (dcnt_q == 2'd3) pst_d = P_RESYNC;
            else                dcnt_d = dcnt_q + 2'd1;
          end else if (message_i == SOH) begin
            // Short digit field is a framing error; this SOH is the resync point.
            pst_d = P_MSG_START;
            if (dcnt_q == 2'd3) begin
              msg_rcv_d = 1'b1;
              msg_src_d = msg_host_i;
            end
          end else begin
            pst_d = P_RESYNC;
          end
        end
        P_SKIP:   if (message_i == SOH) pst_d = P_FIELD;
        P_RESYNC: if (message_i == SOH) pst_d = P_MSG_START;
        default:  pst_d = P_MSG_START;
      endcase
    end
  end

`ifdef FIX_CHECKSUM_EN
  logic ck_ok, checksum_ok_q;

  fix_checksum u_checksum (
    .clk           (clk),
    .rst           (rst),
    .byte_i        (message_i),
    .byte_en_i     (byte_ok),
    .msg_first_i   (byte_ok && pst_eff == P_MSG_START),
    .field_first_i (byte_ok && (pst_eff == P_MSG_START || pst_eff == P_FIELD)),
    .digit_clear_i (byte_ok && pst_eff == P_GOT10 && message_i == ASCII_EQ),
    .digit_en_i    (byte_ok && pst_eff == P_DIGITS && is_digit(message_i) &&
                    dcnt_q != 2'd3),
    .ok_o          (ck_ok)
  );

  // Checksum verdict is registered alongside the end-of-message pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) checksum_ok_q <= 1'b0;
    else      checksum_ok_q <= msg_rcv_d & ck_ok;
  end

  assign checksum_ok_o = checksum_ok_q;
`else
  assign checksum_ok_o = 1'b1;
`endif

  assign connect_req_o         = connect_req_q;
  assign connect_addr_o        = connect_addr_q;
  assign disconnect_o          = disconnect_q;
  assign disconnect_host_num_o = disc_host_q;
  assign busy_o                = busy_q;
  assign timeout_o             = timeout_q;
  assign message_received_o    = msg_rcv_q;
  assign msg_src_o             = msg_src_q;

  // Per-host CONNECTED flags straight from the state array.
  always_comb begin
    for (int i = 0; i < NUM_HOSTS; i++)
      host_connected_o[i] = (host_q[i] == HOST_CONNECTED);
  end

endmodule

// File: doc/fix_session_mgr.md
FIX_SESSION_MGR -- requirements
Module: fix_session_mgr

Interface
REQ-001 Parameter NUM_HOSTS, default 4: number of remote hosts managed; SHALL be a power of two, at least 2.
REQ-002 Parameter HOST_W, default $clog2(NUM_HOSTS): host address width, derived.
REQ-003 Parameter CONN_TIMEOUT, default 1024: cycles allowed between connect request and TOE acknowledge.
REQ-004 clk  in  1  single clock; all logic rising-edge.
REQ-005 rst  in  1  asynchronous, active-low reset.
REQ-006 connect_i  in  1  app request to open a session; connect_to_host_i  in  HOST_W  target host.
REQ-007 disconnect_i  in  1  app request to close a session; disconnect_host_i  in  HOST_W  target host.
REQ-008 connected_i  in  1  TOE connect acknowledge; connected_host_addr_i  in  HOST_W  acknowledged host.
REQ-009 message_i  in  8  received byte; valid_i  in  1  byte strobe; msg_host_i  in  HOST_W  source host.
REQ-010 connect_req_o  out  1  one-cycle request to TOE FIFO; connect_addr_o  out  HOST_W  its host.
REQ-011 disconnect_o  out  1  one-cycle request to TOE FIFO; disconnect_host_num_o  out  HOST_W  its host.
REQ-012 busy_o  out  1  connect attempt outstanding; timeout_o  out  1  one-cycle attempt-expired pulse.
REQ-013 host_connected_o  out  NUM_HOSTS  per-host CONNECTED flag.
REQ-014 message_received_o  out  1  one-cycle end-of-message pulse; msg_src_o  out  HOST_W  its host; checksum_ok_o  out  1  valid with the pulse.

Function
REQ-015 Per-host FSM: IDLE, CONNECTING, CONNECTED, DISCONNECTING.
REQ-016 connect_i with target in IDLE and busy_o low: target -> CONNECTING; next cycle connect_req_o=1, connect_addr_o=target; busy_o high; timeout counter cleared.
REQ-017 connect_i while busy_o high or target not IDLE: ignored, no outputs.
REQ-018 connected_i with address in CONNECTING: that host -> CONNECTED, busy_o low next cycle; acknowledge for any other state ignored.
REQ-019 Counter reaching CONN_TIMEOUT-1 in CONNECTING: host -> IDLE, timeout_o pulses once, busy_o low.
REQ-020 connected_i on the expiry cycle: acknowledge wins, no timeout_o.
REQ-021 disconnect_i with target CONNECTED or CONNECTING: target -> DISCONNECTING; next cycle disconnect_o=1, disconnect_host_num_o=target; following cycle -> IDLE; aborting a CONNECTING host clears busy_o, no timeout_o.
REQ-022 Same-cycle connect_i and disconnect_i: both processed if targets differ; same target: disconnect wins.
REQ-023 Bytes with valid_i low or msg_host_i not CONNECTED: discarded, parser unaffected.
REQ-024 Parser (one stream; host change mid-message restarts it): field starts after SOH (0x01) or message start; field "10=" followed by 3 ASCII digits then SOH ends message.
REQ-025 message_received_o pulses the cycle after terminating SOH; msg_src_o = msg_host_i of that byte.
REQ-026 Checksum: sum of all bytes before "10=" field, modulo 256 (8-bit wraparound); checksum_ok_o=1 when equal to decimal digit value.
REQ-027 Non-digit in checksum field, or more than 3 digits: message discarded, no pulse, parser resyncs at next SOH.

Reset
REQ-028 Reset low: all hosts IDLE, counter 0, parser at message start, accumulator 0.
REQ-029 All outputs 0 during and after reset until stimulus; reset mid-attempt or mid-message abandons it, no pulses emitted.

Configuration
REQ-030 Macro FIX_CHECKSUM_EN defined: accumulator and compare per REQ-026.
REQ-031 Macro undefined: no accumulator; checksum_ok_o tied 1; digit field still parsed for framing; REQ-027 still applies.

Structure
REQ-032 Package fix_pkg SHALL hold host_state_t enum, SOH constant 8'h01, ASCII constants for '1','0','=','0'-'9'.
REQ-033 Sub-module fix_checksum SHALL hold accumulator, digit decoder and compare; instantiated only under FIX_CHECKSUM_EN.

Verification
REQ-034 Connect host 2; TOE ack host 2 after 3 cycles -> connect_req_o one pulse, addr 2; host_connected_o=4'b0100; busy_o low.
REQ-035 CONN_TIMEOUT=16, connect host 1, no ack -> timeout_o one pulse 16 cycles later; host 1 IDLE; second connect then accepted.
REQ-036 Host 0 CONNECTED; bytes "A",0x01,"10=066",0x01 -> message_received_o, msg_src_o=0, checksum_ok_o=1; with "10=067" -> checksum_ok_o=0 (1 without macro).
REQ-037 Same bytes from unconnected host 3 -> no message_received_o.
REQ-038 Connect host 1 pending, disconnect host 1 same cycle as connected_i host 1 -> disconnect_o addr 1, host 1 IDLE, no timeout_o.
REQ-039 Reset low mid-message and mid-attempt -> all outputs 0; fresh message after release parsed correctly.
